imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, instruction-memory word-address width (depth 2^ADDR_W words).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rstN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a program load.
REQ-005 SHALL have port byteIn  input  8  incoming program byte.
REQ-006 SHALL have port byteValid  input  1  byteIn holds a valid byte.
REQ-007 SHALL have port byteReady  output  1  loader accepts byteIn this cycle; a transfer occurs when byteValid and byteReady are both high.
REQ-008 SHALL have port wrEn  output  1  instruction-memory write strobe.
REQ-009 SHALL have port wrAddr  output  ADDR_W  instruction-memory word address.
REQ-010 SHALL have port wrData  output  32  instruction word to write.
REQ-011 SHALL have port cpuHold  output  1  high holds the processor's program counter in reset.
REQ-012 SHALL have port done  output  1  high while a load has completed successfully.
REQ-013 SHALL have port csumErr  output  1  high after a load failed its checksum.

Function
REQ-014 SHALL implement states IDLE, LEN, BYTES, WRITE, CSUM, DONE, ERR.
REQ-015 IDLE: byteReady=0, cpuHold=1; start -> LEN next cycle.
REQ-016 LEN: byteReady=1; first transfer captures word count N (8 bits); N=0 or N>2^ADDR_W SHALL be clamped to 2^ADDR_W; -> BYTES.
REQ-017 BYTES: byteReady=1; four transfers SHALL assemble a word big-endian (first byte -> wrData[31:24]); after the 4th transfer -> WRITE.
REQ-018 WRITE: byteReady=0, wrEn=1 for exactly one cycle with wrAddr=word counter and wrData=assembled word; word counter then increments.
REQ-019 After WRITE: if words written < N -> BYTES; else -> CSUM (macro defined) or DONE (macro undefined).
REQ-020 wrEn SHALL be 0 in every state other than WRITE; wrAddr starts at 0 on every load and never wraps within a load.
REQ-021 Throughput: minimum 5 cycles per word (4 transfer cycles + 1 write cycle); byteValid gaps stall without losing assembled bytes.
REQ-022 DONE: cpuHold=0, done=1, byteReady=0; start -> LEN with cpuHold=1 and done=0 from the next cycle.
REQ-023 start SHALL be ignored in LEN, BYTES, WRITE and CSUM.
REQ-024 Bytes presented while byteReady=0 SHALL NOT be consumed.

Reset
REQ-025 rstN low SHALL immediately force state IDLE, word counter 0, byte counter 0, checksum 0, byteReady=0, wrEn=0, wrAddr=0, wrData=0, cpuHold=1, done=0, csumErr=0.
REQ-026 Reset mid-load SHALL abandon the load; already-written memory words are not cleared; a new start is required.

Configuration
REQ-027 Macro IMEM_LOADER_CHECKSUM_EN SHALL enable checksum: 8-bit modulo-256 sum of the length byte and all data bytes.
REQ-028 With the macro: CSUM state byteReady=1 accepts one checksum byte; total sum including it == 0 -> DONE, else -> ERR (cpuHold=1, csumErr=1, done=0); start from ERR -> LEN and clears csumErr.
REQ-029 Without the macro: no CSUM or ERR state, no checksum logic, csumErr tied to 0.

Verification
REQ-030 Reset, then start, bytes 02, 11 22 33 44, AA BB CC DD -> writes 0x11223344 @0 and 0xAABBCCDD @1, one wrEn cycle each, then done=1, cpuHold=0.
REQ-031 byteValid toggled every other cycle during a 1-word load -> word assembled correctly, single wrEn, no byte lost or duplicated.
REQ-032 Length byte 00 (ADDR_W=5) -> 32 words written at addresses 0..31, done only after address 31.
REQ-033 rstN pulsed low after 2 bytes of word 0 -> all outputs at reset values immediately; following start and full load -> correct words from address 0.
REQ-034 Macro on: length 01, bytes 01 02 03 04, checksum F5 -> done=1; checksum F4 -> csumErr=1, cpuHold=1.
REQ-035 start pulsed during BYTES -> ignored, load completes unchanged; start in DONE -> cpuHold=1 next cycle, new load from address 0.

Source files
------------

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// imem_loader : streams a length-prefixed, big-endian program into instruction
// memory while holding the CPU. Option macro: IMEM_LOADER_CHECKSUM_EN. Rev 1.0
// ============================================================================
module imem_loader #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              start,
  input  logic [7:0]        byteIn,
  input  logic              byteValid,
  output logic              byteReady,
  output logic              wrEn,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [31:0]       wrData,
  output logic              cpuHold,
  output logic              done,
  output logic              csumErr
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN, BYTES, WRITE, CSUM, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, LEN, BYTES, WRITE, DONE} state_t;
`endif

  state_t          state_q, state_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [ADDR_W:0] wcnt_q, wcnt_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [31:0]     data_q, data_d;
  logic            begin_load;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      sum_q, sum_d;
  logic [7:0]      sum_add;
  assign sum_add = sum_q + byteIn;
`else
  assign csumErr = 1'b0;
`endif

  // wcnt_q is one bit wider than the address so a full-depth load can finish
  assign wrAddr = wcnt_q[ADDR_W-1:0];
  assign wrData = data_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wcnt_d     = wcnt_q;
    bcnt_d     = bcnt_q;
    data_d     = data_q;
    byteReady  = 1'b0;
    wrEn       = 1'b0;
    cpuHold    = 1'b1;
    done       = 1'b0;
    begin_load = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
    csumErr    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        begin_load = start;
      end
      LEN: begin
        byteReady = 1'b1;
        if (byteValid) begin
          if (byteIn == 8'd0 || 32'(byteIn) > 32'(DEPTH)) begin
            len_d = DEPTH;
          end else begin
            len_d = (ADDR_W+1)'(byteIn);
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d = sum_add;
`endif
          state_d = BYTES;
        end
      end
      BYTES: begin
        byteReady = 1'b1;
        if (byteValid) begin
          data_d = {data_q[23:0], byteIn};
          bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d  = sum_add;
`endif
          if (bcnt_q == 2'd3) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        wrEn   = 1'b1;
        wcnt_d = wcnt_q + 1'b1;
        if ((wcnt_q + 1'b1) < len_q) begin
          state_d = BYTES;
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CSUM;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        byteReady = 1'b1;
        if (byteValid) begin
          state_d = (sum_add == 8'd0) ? DONE : ERR;
        end
      end
      ERR: begin
        csumErr    = 1'b1;
        begin_load = start;
      end
`endif
      DONE: begin
        cpuHold    = 1'b0;
        done       = 1'b1;
        begin_load = start;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Every load restarts at address 0 with fresh counters
    if (begin_load) begin
      state_d = LEN;
      wcnt_d  = '0;
      bcnt_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      data_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      data_q  <= data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// tb_imem_loader : randomized scoreboard bench for imem_loader; also covers the
// checksum path when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rstN = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        byteIn = 8'h00;
  logic              byteValid = 1'b0;
  logic              byteReady, wrEn, cpuHold, done, csumErr;
  logic [ADDR_W-1:0] wrAddr;
  logic [31:0]       wrData;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstN(rstN), .start(start), .byteIn(byteIn), .byteValid(byteValid),
    .byteReady(byteReady), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .cpuHold(cpuHold), .done(done), .csumErr(csumErr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_checks = 0;
  int  n_fail   = 0;
  logic prev_wr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (rstN === 1'b1 && wrEn === 1'b1) begin
      check("wr_single_cycle", {31'd0, prev_wr}, 32'd0);
      check("no_done_during_write", {31'd0, done}, 32'd0);
      if (exp_q.size() == 0) begin
        fail_now("unexpected_write");
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", {{(32-ADDR_W){1'b0}}, wrAddr}, {{(32-ADDR_W){1'b0}}, mon_e.addr});
        check("wr_data", wrData, mon_e.data);
      end
    end
    prev_wr <= (rstN === 1'b1) && (wrEn === 1'b1);
  end

  task automatic send_byte(input logic [7:0] b, input int gap_mode, input bit pulse_start);
    int guard;
    @(negedge clk);
    if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
      byteValid = 1'b0;
      byteIn    = 8'($urandom);
      @(negedge clk);
    end
    byteValid = 1'b1;
    byteIn    = b;
    if (pulse_start) start = 1'b1;
    guard = 0;
    while (!byteReady && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!byteReady) fail_now("byte_ready_timeout");
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    byteValid = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_cpuHold", {31'd0, cpuHold}, 32'd1);
    check("start_done", {31'd0, done}, 32'd0);
    check("start_csumErr", {31'd0, csumErr}, 32'd0);
    check("start_byteReady", {31'd0, byteReady}, 32'd1);
  endtask

  // Reference model: expected writes and outcome follow directly from the
  // length rule, big-endian packing and modulo-256 sum.
  task automatic do_load(input logic [7:0] len, input logic [31:0] fixed[$],
                         input int gap_mode, input bit start_mid, input bit bad_csum);
    int          n;
    int          guard;
    logic [31:0] words[$];
    logic [7:0]  sum;
    logic [7:0]  b;
    bit          exp_ok;
    wr_t         e;
    n = (len == 8'd0 || int'(len) > DEPTH) ? DEPTH : int'(len);
    for (int i = 0; i < n; i++) begin
      words.push_back((i < fixed.size()) ? fixed[i] : $urandom);
      e.addr = ADDR_W'(i);
      e.data = words[i];
      exp_q.push_back(e);
    end
    do_start();
    send_byte(len, gap_mode, 1'b0);
    sum = len;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b   = words[i][31-8*k -: 8];
        sum = sum + b;
        send_byte(b, gap_mode, start_mid && i == 0 && k == 2);
      end
    end
    exp_ok = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
    b = 8'(8'd0 - sum);
    if (bad_csum) begin
      b      = b - 8'd1;
      exp_ok = 1'b0;
    end
    send_byte(b, gap_mode, 1'b0);
`else
    if (bad_csum) exp_ok = 1'b1;
`endif
    @(negedge clk);
    byteValid = 1'b0;
    guard = 0;
    while (!done && !csumErr && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("load_done", {31'd0, done}, {31'd0, exp_ok});
    check("load_csumErr", {31'd0, csumErr}, {31'd0, !exp_ok});
    check("load_cpuHold", {31'd0, cpuHold}, {31'd0, !exp_ok});
    check("writes_drained", exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byteReady"}, {31'd0, byteReady}, 32'd0);
    check({tag, "_wrEn"}, {31'd0, wrEn}, 32'd0);
    check({tag, "_wrAddr"}, {{(32-ADDR_W){1'b0}}, wrAddr}, 32'd0);
    check({tag, "_wrData"}, wrData, 32'd0);
    check({tag, "_cpuHold"}, {31'd0, cpuHold}, 32'd1);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_csumErr"}, {31'd0, csumErr}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] fx[$];
    logic [7:0]  rl;

    #1 rstN = 1'b0;
    #2 check_reset_outputs("reset");
    @(negedge clk);
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_ready", {31'd0, byteReady}, 32'd0);
    check("idle_hold", {31'd0, cpuHold}, 32'd1);

    // Two-word reference program
    fx.delete();
    fx.push_back(32'h11223344);
    fx.push_back(32'hAABBCCDD);
    do_load(8'h02, fx, 0, 1'b0, 1'b0);

    // byteValid alternating on a one-word load
    fx.delete();
    do_load(8'h01, fx, 1, 1'b0, 1'b0);

    // Bytes offered while in DONE must not be consumed
    @(negedge clk);
    byteValid = 1'b1;
    byteIn    = 8'h03;
    repeat (3) @(negedge clk);
    check("done_holds", {31'd0, done}, 32'd1);
    check("done_no_ready", {31'd0, byteReady}, 32'd0);

    // start pulsed mid-word is ignored; load also restarts from DONE
    do_load(8'h03, fx, 2, 1'b1, 1'b0);

    // Length 0 clamps to full depth
    do_load(8'h00, fx, 0, 1'b0, 1'b0);

    // Reset after two data bytes abandons the load
    do_start();
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h12, 0, 1'b0);
    send_byte(8'h34, 0, 1'b0);
    #2 rstN = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    byteValid = 1'b0;
    rstN      = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", {31'd0, byteReady}, 32'd0);
    fx.push_back(32'hCAFEF00D);
    do_load(8'h01, fx, 0, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    fx.delete();
    fx.push_back(32'h01020304);
    do_load(8'h01, fx, 0, 1'b0, 1'b0);
    do_load(8'h01, fx, 0, 1'b0, 1'b1);
    fx.delete();
    do_load(8'h02, fx, 2, 1'b0, 1'b0);
`endif

    // Randomized loads, including lengths beyond the memory depth
    fx.delete();
    for (int r = 0; r < 5; r++) begin
      rl = (r == 4) ? 8'd200 : 8'($urandom_range(1, 40));
      do_load(rl, fx, 2, r[0], 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
